// File: rtl/trace_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH trace streams onto one
// registered output stage, with beat and packet statistics.
module trace_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int CNT_WIDTH  = 32,
    localparam int KW        = DATA_WIDTH / 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          cfg_mask,
    input  logic [NUM_CH-1:0]          s_valid,
    output logic [NUM_CH-1:0]          s_ready,
    input  logic [NUM_CH*KW-1:0]       s_keep,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]          s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [KW-1:0]              m_keep,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_last,
    output logic [CH_W-1:0]            m_chan,
    output logic [CNT_WIDTH-1:0]       stat_beats,
    output logic [CNT_WIDTH-1:0]       stat_pkts
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] lock_id;
    logic [CH_W-1:0] gnt_id;
    logic [CH_W-1:0] nxt_ptr;
    logic            gnt_vld;
    logic            load_en;
    logic            accept;

    // Scan downwards so the channel closest to rr_ptr is written last and wins.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        if (state == LOCKED) begin
            gnt_vld = 1'b1;
            gnt_id  = lock_id;
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_CH;
                if (s_valid[idx] && cfg_mask[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = CH_W'(idx);
                end
            end
        end
    end

    assign load_en = !m_valid || m_ready;
    assign accept  = gnt_vld && load_en && s_valid[gnt_id];
    assign nxt_ptr = (gnt_id == CH_W'(NUM_CH - 1)) ? '0 : gnt_id + CH_W'(1);

    always_comb begin
        s_ready = '0;
        if (rst_n && gnt_vld && load_en) begin
            s_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            lock_id    <= '0;
            m_valid    <= 1'b0;
            m_keep     <= '0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_chan     <= '0;
            stat_beats <= '0;
            stat_pkts  <= '0;
        end else begin
            if (load_en) begin
                m_valid <= accept;
                if (accept) begin
                    m_data <= s_data[int'(gnt_id) * DATA_WIDTH +: DATA_WIDTH];
                    m_keep <= s_keep[int'(gnt_id) * KW +: KW];
                    m_last <= s_last[gnt_id];
                    m_chan <= gnt_id;
                end
            end
            if (m_valid && m_ready) begin
                stat_beats <= stat_beats + CNT_WIDTH'(1);
                if (m_last) begin
                    stat_pkts <= stat_pkts + CNT_WIDTH'(1);
                end
            end
            if (accept) begin
                if (s_last[gnt_id]) begin
                    state  <= IDLE;
                    rr_ptr <= nxt_ptr;
                end else begin
                    state   <= LOCKED;
                    lock_id <= gnt_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Bench for trace_stream_arbiter: directed table, random traffic with a
// behavioural model and scoreboard, async reset and counter wrap.
module tb_trace_stream_arbiter;

    logic           clk;
    logic           rst_n;
    logic [3:0]     cfg_mask;
    logic [3:0]     s_valid;
    logic [3:0]     s_ready;
    logic [255:0]   s_keep;
    logic [2047:0]  s_data;
    logic [3:0]     s_last;
    logic           m_valid;
    logic           m_ready;
    logic [63:0]    m_keep;
    logic [511:0]   m_data;
    logic           m_last;
    logic [1:0]     m_chan;
    logic [31:0]    stat_beats;
    logic [31:0]    stat_pkts;

    logic           w_mask, w_valid, w_ready, w_last;
    logic [0:0]     w_keep, w_m_keep, w_m_chan;
    logic [7:0]     w_data, w_m_data;
    logic           w_m_valid, w_m_ready, w_m_last;
    logic [3:0]     w_beats, w_pkts;

    trace_stream_arbiter dut (
        .clk(clk), .rst_n(rst_n), .cfg_mask(cfg_mask),
        .s_valid(s_valid), .s_ready(s_ready), .s_keep(s_keep),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid),
        .m_ready(m_ready), .m_keep(m_keep), .m_data(m_data),
        .m_last(m_last), .m_chan(m_chan), .stat_beats(stat_beats),
        .stat_pkts(stat_pkts)
    );

    trace_stream_arbiter #(.NUM_CH(1), .DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .cfg_mask(w_mask),
        .s_valid(w_valid), .s_ready(w_ready), .s_keep(w_keep),
        .s_data(w_data), .s_last(w_last), .m_valid(w_m_valid),
        .m_ready(w_m_ready), .m_keep(w_m_keep), .m_data(w_m_data),
        .m_last(w_m_last), .m_chan(w_m_chan), .stat_beats(w_beats),
        .stat_pkts(w_pkts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] sv;
        logic [3:0] sl;
        logic [3:0] mask;
        logic       mr;
        logic [3:0] rdy;
        logic       mv;
        logic [1:0] ch;
        logic       lst;
        int         beats;
        int         pkts;
    } vec_t;

    int compared = 0;
    int mismatched = 0;

    // behavioural model of the output stage and arbitration
    logic         e_valid;
    logic [511:0] e_data;
    logic [63:0]  e_keep;
    logic         e_last;
    int           e_chan;
    logic [31:0]  e_beats, e_pkts;
    int           owner;
    int           ptr;

    // traffic generator and scoreboard
    logic [3:0]   sacc;
    int           src_left[4];
    int           src_seq[4];
    int           out_seq[4];
    bit           sb_on;
    bit           in_pkt;
    int           pkt_ch;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_data = '0; e_keep = '0; e_last = 1'b0; e_chan = 0;
        e_beats = '0; e_pkts = '0; owner = -1; ptr = 0;
    endtask

    task automatic step(input bit use_t, input vec_t v);
        int g;
        bit load, acc;
        logic [3:0] er;
        @(negedge clk);
        load = !e_valid || m_ready;
        g = -1;
        if (owner >= 0) g = owner;
        else for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (g < 0 && s_valid[i] && cfg_mask[i]) g = i;
        end
        er = '0;
        if (load && g >= 0) er[g] = 1'b1;
        chk("s_ready", 512'(s_ready), 512'(er));
        chk("m_valid", 512'(m_valid), 512'(e_valid));
        if (e_valid) begin
            chk("m_data", m_data, e_data);
            chk("m_keep", 512'(m_keep), 512'(e_keep));
            chk("m_last", 512'(m_last), 512'(e_last));
            chk("m_chan", 512'(m_chan), 512'(e_chan));
        end
        chk("stat_beats", 512'(stat_beats), 512'(e_beats));
        chk("stat_pkts", 512'(stat_pkts), 512'(e_pkts));
        if (use_t) begin
            chk("tbl_ready", 512'(s_ready), 512'(v.rdy));
            chk("tbl_valid", 512'(m_valid), 512'(v.mv));
            if (v.mv) begin
                chk("tbl_chan", 512'(m_chan), 512'(v.ch));
                chk("tbl_last", 512'(m_last), 512'(v.lst));
            end
            chk("tbl_beats", 512'(stat_beats), 512'(v.beats));
            chk("tbl_pkts", 512'(stat_pkts), 512'(v.pkts));
        end
        sacc = s_valid & s_ready;
        if (sb_on && m_valid && m_ready) begin
            int c;
            c = int'(m_chan);
            if (in_pkt) chk("atomic_chan", 512'(m_chan), 512'(pkt_ch));
            chk("seq", 512'(m_data[31:8]), 512'(24'(out_seq[c])));
            chk("tag", 512'(m_data[7:0]), 512'(c));
            out_seq[c]++;
            in_pkt = !m_last;
            pkt_ch = c;
        end
        acc = (g >= 0) && load && s_valid[g];
        if (e_valid && m_ready) begin
            e_beats++;
            if (e_last) e_pkts++;
        end
        if (load) begin
            e_valid = acc;
            if (acc) begin
                e_data = s_data[g*512 +: 512];
                e_keep = s_keep[g*64 +: 64];
                e_last = s_last[g];
                e_chan = g;
                if (s_last[g]) begin
                    owner = -1;
                    ptr = (g + 1) % 4;
                end else begin
                    owner = g;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int c);
        for (int w = 0; w < 16; w++) s_data[c*512 + w*32 +: 32] = $urandom;
        s_keep[c*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic gen(input bit stop);
        for (int c = 0; c < 4; c++) begin
            if (s_valid[c] && sacc[c]) begin
                src_seq[c]++;
                src_left[c]--;
            end
            if (s_valid[c] && !sacc[c]) continue;
            if (src_left[c] == 0 && stop) begin
                s_valid[c] = 1'b0;
                continue;
            end
            if (src_left[c] == 0) src_left[c] = $urandom_range(1, 4);
            s_valid[c] = ($urandom_range(0, 3) != 0);
            fill(c);
            s_data[c*512 +: 8] = 8'(c);
            s_data[c*512 + 8 +: 24] = 24'(src_seq[c]);
            s_last[c] = (src_left[c] == 1);
        end
    endtask

    vec_t tbl[$];
    vec_t nv;

    initial begin
        nv = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 0, 0};
        rst_n = 1'b0; cfg_mask = 4'hF; s_valid = 4'hF; s_last = '0;
        s_keep = '0; s_data = '0; m_ready = 1'b1; sacc = '0;
        w_mask = 1'b1; w_valid = 1'b0; w_last = 1'b0; w_keep = '0;
        w_data = '0; w_m_ready = 1'b1;
        sb_on = 0; in_pkt = 0; pkt_ch = 0;
        for (int c = 0; c < 4; c++) begin
            src_left[c] = 0; src_seq[c] = 0; out_seq[c] = 0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 512'(m_valid), 512'(0));
        chk("rst_s_ready", 512'(s_ready), 512'(0));
        chk("rst_beats", 512'(stat_beats), 512'(0));
        s_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        tbl.push_back('{4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 0, 0});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1, 0, 0});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1, 1, 1});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 1'b1, 2, 2});
        tbl.push_back('{4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 1'b1, 3, 3});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 4, 4});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 5, 5});
        tbl.push_back('{4'h1, 4'h0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 5, 5});
        tbl.push_back('{4'h1, 4'h0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 5, 5});
        tbl.push_back('{4'h1, 4'h1, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 6, 5});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 7, 5});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 8, 6});
        tbl.push_back('{4'h6, 4'h4, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 8, 6});
        tbl.push_back('{4'h6, 4'h4, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 8, 6});
        tbl.push_back('{4'h6, 4'h4, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 9, 6});
        tbl.push_back('{4'h6, 4'h6, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 10, 6});
        tbl.push_back('{4'h4, 4'h4, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1, 11, 6});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1, 12, 7});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 13, 8});
        tbl.push_back('{4'h8, 4'h0, 4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 13, 8});
        tbl.push_back('{4'h8, 4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 13, 8});
        tbl.push_back('{4'h8, 4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 13, 8});
        tbl.push_back('{4'h8, 4'h0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 13, 8});
        tbl.push_back('{4'h8, 4'h8, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b0, 14, 8});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 15, 8});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 16, 9});
        tbl.push_back('{4'h2, 4'h0, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 16, 9});
        tbl.push_back('{4'h2, 4'h0, 4'hD, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 16, 9});
        tbl.push_back('{4'h3, 4'h3, 4'hD, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 17, 9});
        tbl.push_back('{4'h3, 4'h3, 4'hD, 1'b1, 4'h1, 1'b1, 2'd1, 1'b1, 18, 9});
        tbl.push_back('{4'h2, 4'h2, 4'hD, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1, 19, 10});
        tbl.push_back('{4'h2, 4'h2, 4'hD, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 20, 11});
        tbl.push_back('{4'h2, 4'h2, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 20, 11});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1, 20, 11});
        tbl.push_back('{4'h0, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 21, 12});

        foreach (tbl[r]) begin
            s_valid = tbl[r].sv;
            s_last = tbl[r].sl;
            cfg_mask = tbl[r].mask;
            m_ready = tbl[r].mr;
            for (int c = 0; c < 4; c++) fill(c);
            step(1, tbl[r]);
        end

        // randomized traffic, masks and back-pressure
        s_valid = '0;
        sb_on = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 50 == 0) cfg_mask = 4'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            gen(0);
            step(0, nv);
        end
        cfg_mask = 4'hF;
        for (int n = 0; n < 200; n++) begin
            m_ready = 1'b1;
            gen(1);
            step(0, nv);
        end
        s_valid = '0;
        repeat (3) step(0, nv);
        sb_on = 0;

        // async reset in the middle of a ch2 packet
        s_valid = 4'h4; s_last = 4'h0;
        fill(2);
        step(0, nv);
        fill(2);
        step(0, nv);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 512'(m_valid), 512'(0));
        chk("arst_m_data", m_data, 512'(0));
        chk("arst_m_keep", 512'(m_keep), 512'(0));
        chk("arst_m_last", 512'(m_last), 512'(0));
        chk("arst_m_chan", 512'(m_chan), 512'(0));
        chk("arst_beats", 512'(stat_beats), 512'(0));
        chk("arst_pkts", 512'(stat_pkts), 512'(0));
        chk("arst_s_ready", 512'(s_ready), 512'(0));
        model_reset();
        s_valid = 4'hF; s_last = 4'hF;
        for (int c = 0; c < 4; c++) fill(c);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, nv);
        chk("post_rst_first_chan", 512'({m_valid, m_chan}), 512'({1'b1, 2'd0}));
        s_valid = '0;
        repeat (3) step(0, nv);

        // single-channel instance: counter wrap and constant m_chan
        w_valid = 1'b1; w_last = 1'b1;
        for (int n = 0; n < 17; n++) begin
            w_data = 8'($urandom);
            @(negedge clk);
            chk("w_s_ready", 512'(w_ready), 512'(1));
            if (w_m_valid) chk("w_m_chan", 512'(w_m_chan), 512'(0));
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("w_beats_wrap", 512'(w_beats), 512'(4'd1));
        chk("w_pkts_wrap", 512'(w_pkts), 512'(4'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
